mips_imem_loader: RTL and testbench



---
 rtl/mips_pkg.sv | 15 +
 rtl/imem_array.sv | 23 ++
 rtl/mips_imem_loader.sv | 159 +++++++++++++++
 tb/tb_mips_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-memory loader.
package mips_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StHold,
      StRun,
      StErr
   } loader_state_t;

   // sll $0,$0,0
   localparam logic [31:0] NopInstr = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [31:0]                    wdata,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [31:0]                    rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/mips_imem_loader.sv
// Loads a big-endian byte stream into instruction memory, holds the core in reset while
// loading, then serves combinational fetches bounded by the number of words committed.
module mips_imem_loader
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load_start,
   input  logic                         s_valid,
   input  logic [7:0]                   s_data,
   input  logic                         s_last,
   output logic                         s_ready,
   input  logic [31:0]                  instr_addr,
   output logic [31:0]                  instr_out,
   output logic                         core_reset,
   output logic                         load_done,
   output logic                         load_err,
   output logic [$clog2(DEPTH_WORDS):0] words_loaded
);

   localparam int unsigned AW  = $clog2(DEPTH_WORDS);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   loader_state_t  r_state;
   logic           r_core_reset;
   logic           r_load_done;
   logic           r_load_err;
   logic [CW-1:0]  r_words;
   logic [1:0]     r_byte_idx;
   logic [23:0]    r_word_buf;
   logic [HCW-1:0] r_hold_cnt;

   logic           w_full;
   logic           w_we;
   logic [31:0]    w_wdata;
   logic [31:0]    w_offset;
   logic           w_hit;
   logic [31:0]    w_rdata;

   assign w_full  = (r_words == CW'(DEPTH_WORDS));
   // A restart on the same cycle drops the byte, so it never reaches the array.
   assign w_we    = (r_state == StLoad) && s_valid && !load_start && !w_full &&
                    (r_byte_idx == 2'd3);
   assign w_wdata = {r_word_buf, s_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_core_reset <= 1'b1;
         r_load_done  <= 1'b0;
         r_load_err   <= 1'b0;
         r_words      <= '0;
         r_byte_idx   <= '0;
         r_word_buf   <= '0;
         r_hold_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (load_start) begin
                  r_state    <= StLoad;
                  r_words    <= '0;
                  r_byte_idx <= '0;
               end
            end
            StLoad: begin
               if (load_start) begin
                  r_words    <= '0;
                  r_byte_idx <= '0;
               end else if (s_valid) begin
                  if (w_full) begin
                     r_state    <= StErr;
                     r_load_err <= 1'b1;
                  end else if (r_byte_idx == 2'd3) begin
                     r_words    <= r_words + CW'(1);
                     r_byte_idx <= '0;
                     if (s_last) begin
                        r_state    <= StHold;
                        r_hold_cnt <= '0;
                     end
                  end else if (s_last) begin
                     r_state    <= StErr;
                     r_load_err <= 1'b1;
                     r_byte_idx <= '0;
                  end else begin
                     r_word_buf <= {r_word_buf[15:0], s_data};
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end
            end
            StHold: begin
               if (r_hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
                  r_state      <= StRun;
                  r_core_reset <= 1'b0;
                  r_load_done  <= 1'b1;
               end else begin
                  r_hold_cnt <= r_hold_cnt + HCW'(1);
               end
            end
            StRun: begin
               if (load_start) begin
                  r_state      <= StLoad;
                  r_core_reset <= 1'b1;
                  r_load_done  <= 1'b0;
                  r_words      <= '0;
                  r_byte_idx   <= '0;
               end
            end
            StErr: begin
               if (load_start) begin
                  r_state    <= StLoad;
                  r_load_err <= 1'b0;
                  r_words    <= '0;
                  r_byte_idx <= '0;
               end
            end
            default: begin
               r_state      <= StIdle;
               r_core_reset <= 1'b1;
               r_load_done  <= 1'b0;
               r_load_err   <= 1'b0;
            end
         endcase
      end
   end

   imem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk  (clk),
      .we   (w_we),
      .waddr(r_words[AW-1:0]),
      .wdata(w_wdata),
      .raddr(w_offset[AW+1:2]),
      .rdata(w_rdata)
   );

   // Bounding by words_loaded keeps stale contents from earlier loads unreachable.
   assign w_offset = instr_addr - BASE_ADDR;
   assign w_hit    = (w_offset[1:0] == 2'b00) && ({2'b00, w_offset[31:2]} < 32'(r_words));

   always_comb begin
      instr_out = NopInstr;
      if (r_state == StRun && w_hit) begin
         instr_out = w_rdata;
      end
   end

   assign s_ready      = (r_state == StLoad);
   assign core_reset   = r_core_reset;
   assign load_done    = r_load_done;
   assign load_err     = r_load_err;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader: a 1024-word instance and a 2-word overflow instance.
module tb_mips_imem_loader;

   logic        clk;
   logic        reset;
   logic        load_start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic [31:0] instr_addr;

   logic        s_ready,    sm_s_ready;
   logic [31:0] instr_out,  sm_instr_out;
   logic        core_reset, sm_core_reset;
   logic        load_done,  sm_load_done;
   logic        load_err,   sm_load_err;
   logic [10:0] words_loaded;
   logic [1:0]  sm_words_loaded;

   int total = 0;
   int bad   = 0;

   mips_imem_loader #(
      .BASE_ADDR  (32'h0000_0100),
      .DEPTH_WORDS(1024),
      .HOLD_CYCLES(2)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .load_start  (load_start),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .instr_addr  (instr_addr),
      .instr_out   (instr_out),
      .core_reset  (core_reset),
      .load_done   (load_done),
      .load_err    (load_err),
      .words_loaded(words_loaded)
   );

   mips_imem_loader #(
      .BASE_ADDR  (32'h0000_0100),
      .DEPTH_WORDS(2),
      .HOLD_CYCLES(2)
   ) u_small (
      .clk         (clk),
      .reset       (reset),
      .load_start  (load_start),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (sm_s_ready),
      .instr_addr  (instr_addr),
      .instr_out   (sm_instr_out),
      .core_reset  (sm_core_reset),
      .load_done   (sm_load_done),
      .load_err    (sm_load_err),
      .words_loaded(sm_words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Called #1 after the edge that accepted the last byte; counts edges until core_reset drops.
   task automatic wait_run(input string tag);
      int n;
      n = 1;
      check_eq({tag, "_hold_rst"}, 32'(core_reset), 32'd1);
      check_eq({tag, "_hold_rdy"}, 32'(s_ready), 32'd0);
      while (core_reset && n < 20) begin
         tick();
         n++;
      end
      check_eq({tag, "_hold_len"}, 32'(n), 32'd3);
      check_eq({tag, "_done"}, 32'(load_done), 32'd1);
   endtask

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'h00;
      s_last     = 1'b0;
      instr_addr = 32'h0000_0100;
      tick();
      tick();
      check_eq("rst_core_reset", 32'(core_reset), 32'd1);
      check_eq("rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("rst_load_done", 32'(load_done), 32'd0);
      check_eq("rst_load_err", 32'(load_err), 32'd0);
      check_eq("rst_words", 32'(words_loaded), 32'd0);
      check_eq("rst_instr", instr_out, 32'h0);
      reset = 1'b0;
      tick();
      check_eq("idle_s_ready", 32'(s_ready), 32'd0);

      // Basic load: two words.
      pulse_start();
      check_eq("load_s_ready", 32'(s_ready), 32'd1);
      send_byte(8'h24, 1'b0);
      send_byte(8'h08, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b1);
      wait_run("basic");
      check_eq("basic_words", 32'(words_loaded), 32'd2);
      instr_addr = 32'h0000_0100;
      #1 check_eq("basic_w0", instr_out, 32'h2408_0005);
      instr_addr = 32'h0000_0104;
      #1 check_eq("basic_w1", instr_out, 32'h0);

      // Out-of-range fetches.
      instr_addr = 32'h0000_0102;
      #1 check_eq("rd_misaligned", instr_out, 32'h0);
      instr_addr = 32'h0000_00FC;
      #1 check_eq("rd_below_base", instr_out, 32'h0);
      instr_addr = 32'h0000_0108;
      #1 check_eq("rd_beyond", instr_out, 32'h0);

      // Bytes offered in RUN are ignored.
      s_valid = 1'b1;
      s_data  = 8'hFF;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      check_eq("run_no_accept", 32'(words_loaded), 32'd2);

      // Restart from RUN, then the same stream with gaps.
      pulse_start();
      check_eq("restart_core_reset", 32'(core_reset), 32'd1);
      check_eq("restart_s_ready", 32'(s_ready), 32'd1);
      check_eq("restart_words", 32'(words_loaded), 32'd0);
      send_byte(8'h24, 1'b0); tick();
      send_byte(8'h08, 1'b0); tick();
      send_byte(8'h00, 1'b0); tick();
      send_byte(8'h05, 1'b0); tick();
      send_byte(8'h00, 1'b0); tick();
      send_byte(8'h00, 1'b0); tick();
      send_byte(8'h00, 1'b0); tick();
      send_byte(8'h00, 1'b1);
      wait_run("gap");
      check_eq("gap_words", 32'(words_loaded), 32'd2);
      instr_addr = 32'h0000_0100;
      #1 check_eq("gap_w0", instr_out, 32'h2408_0005);

      // Truncated word -> ERR.
      pulse_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b1);
      check_eq("err_load_err", 32'(load_err), 32'd1);
      check_eq("err_core_reset", 32'(core_reset), 32'd1);
      check_eq("err_s_ready", 32'(s_ready), 32'd0);
      check_eq("err_words", 32'(words_loaded), 32'd1);
      check_eq("err_done", 32'(load_done), 32'd0);
      instr_addr = 32'h0000_0100;
      #1 check_eq("err_instr", instr_out, 32'h0);
      tick();
      check_eq("err_sticky", 32'(load_err), 32'd1);

      // Recovery from ERR.
      pulse_start();
      check_eq("recover_err_clr", 32'(load_err), 32'd0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      send_byte(8'hBE, 1'b0);
      send_byte(8'hEF, 1'b1);
      wait_run("recover");
      check_eq("recover_words", 32'(words_loaded), 32'd1);
      #1 check_eq("recover_w0", instr_out, 32'hDEAD_BEEF);
      instr_addr = 32'h0000_0104;
      #1 check_eq("recover_beyond", instr_out, 32'h0);

      // Restart mid-load with a byte on the same cycle: byte dropped.
      pulse_start();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      load_start = 1'b1;
      send_byte(8'hCC, 1'b0);
      load_start = 1'b0;
      check_eq("mid_restart_words", 32'(words_loaded), 32'd0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b1);
      wait_run("mid_restart");
      instr_addr = 32'h0000_0100;
      #1 check_eq("mid_restart_w0", instr_out, 32'h0102_0304);

      // Overflow on the 2-word instance.
      pulse_start();
      for (int i = 1; i <= 9; i++) begin
         send_byte(8'(i), 1'b0);
      end
      check_eq("ovf_err", 32'(sm_load_err), 32'd1);
      check_eq("ovf_words", 32'(sm_words_loaded), 32'd2);
      check_eq("ovf_core_reset", 32'(sm_core_reset), 32'd1);
      check_eq("ovf_mem0", u_small.u_array.r_mem[0], 32'h0102_0304);
      check_eq("ovf_mem1", u_small.u_array.r_mem[1], 32'h0506_0708);
      check_eq("big_no_ovf_err", 32'(load_err), 32'd0);
      check_eq("big_words", 32'(words_loaded), 32'd2);

      // Reset in the middle of a load.
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         send_byte(8'h10 + 8'(i), 1'b0);
      end
      check_eq("pre_rst_words", 32'(words_loaded), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst_core_reset", 32'(core_reset), 32'd1);
      check_eq("mid_rst_s_ready", 32'(s_ready), 32'd0);
      check_eq("mid_rst_words", 32'(words_loaded), 32'd0);
      check_eq("mid_rst_small_err", 32'(sm_load_err), 32'd0);
      tick();
      check_eq("mid_rst_idle", 32'(s_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
